// File: rtl/element_stack_if.sv
// Bundles the element_parser-to-element_stack handshake and the node/status outputs.
interface element_stack_if #(
    parameter int TAG_W = 3,
    parameter int DEPTH = 16
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic             elem_done;
    logic [TAG_W-1:0] elem_tag;
    logic             elem_closing;

    logic             node_valid;
    logic [TAG_W-1:0] node_tag;
    logic [TAG_W-1:0] node_parent;
    logic [SP_W-1:0]  node_depth;
    logic             close_valid;
    logic             doc_complete;
    logic [SP_W-1:0]  depth;
    logic             error;
    logic [1:0]       error_code;

    // Producer side: drives parser results, observes stack results.
    modport master (
        output elem_done, elem_tag, elem_closing,
        input  node_valid, node_tag, node_parent, node_depth,
        input  close_valid, doc_complete, depth, error, error_code
    );

    // element_stack side.
    modport slave (
        input  elem_done, elem_tag, elem_closing,
        output node_valid, node_tag, node_parent, node_depth,
        output close_valid, doc_complete, depth, error, error_code
    );
endinterface

// File: rtl/element_stack.sv
// Open-element stack behind element_parser: emits a node record per opening tag,
// pops on matching closes, and latches overflow/underflow/mismatch errors.
module element_stack #(
    parameter int TAG_W    = 3,
    parameter int DEPTH    = 16,
    parameter int VOID_TAG = 5
) (
    input  logic            clock,
    input  logic            reset,
    element_stack_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             elem_done_q;
    logic [TAG_W-1:0] cap_tag_q, cap_tag_d;
    logic             cap_close_q, cap_close_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             node_valid_q, node_valid_d;
    logic [TAG_W-1:0] node_tag_q, node_tag_d;
    logic [TAG_W-1:0] node_parent_q, node_parent_d;
    logic [SP_W-1:0]  node_depth_q, node_depth_d;
    logic             close_valid_q, close_valid_d;
    logic             doc_complete_q, doc_complete_d;
    logic             error_q, error_d;
    logic [1:0]       error_code_q, error_code_d;
    logic [TAG_W-1:0] stack_q [DEPTH];

    logic             event_s;
    logic             push_s;
    logic             full_s;
    logic             is_void_s;
    logic [PTR_W-1:0] top_idx_s;
    logic [TAG_W-1:0] top_tag_s;

    // Derive the rising-edge event and the top-of-stack view used by EVAL.
    always_comb begin
        event_s   = bus.elem_done & ~elem_done_q;
        full_s    = (sp_q == SP_W'(DEPTH));
        is_void_s = (cap_tag_q == TAG_W'(VOID_TAG));
        top_idx_s = sp_q[PTR_W-1:0] - PTR_W'(1);
        if (sp_q == SP_W'(0)) begin
            top_tag_s = TAG_W'(0);
        end else begin
            top_tag_s = stack_q[top_idx_s];
        end
    end

    // Next-state and registered-output computation for the IDLE/EVAL/ERR machine.
    always_comb begin
        state_d        = state_q;
        cap_tag_d      = cap_tag_q;
        cap_close_d    = cap_close_q;
        sp_d           = sp_q;
        node_valid_d   = 1'b0;
        node_tag_d     = node_tag_q;
        node_parent_d  = node_parent_q;
        node_depth_d   = node_depth_q;
        close_valid_d  = 1'b0;
        doc_complete_d = 1'b0;
        error_d        = error_q;
        error_code_d   = error_code_q;
        push_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    cap_tag_d   = bus.elem_tag;
                    cap_close_d = bus.elem_closing;
                    state_d     = ST_EVAL;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_EVAL: begin
                // Events landing here are dropped: upstream spaces them out.
                state_d = ST_IDLE;
                if (!cap_close_q) begin
                    if (!is_void_s && full_s) begin
                        error_d      = 1'b1;
                        error_code_d = 2'b01;
                        state_d      = ST_ERR;
                    end else begin
                        node_valid_d  = 1'b1;
                        node_tag_d    = cap_tag_q;
                        node_parent_d = top_tag_s;
                        node_depth_d  = sp_q;
                        if (!is_void_s) begin
                            push_s = 1'b1;
                            sp_d   = sp_q + SP_W'(1);
                        end else begin
                            push_s = 1'b0;
                        end
                    end
                end else begin
                    if (sp_q == SP_W'(0)) begin
                        error_d      = 1'b1;
                        error_code_d = 2'b10;
                        state_d      = ST_ERR;
                    end else if (is_void_s || (cap_tag_q != top_tag_s)) begin
                        error_d      = 1'b1;
                        error_code_d = 2'b11;
                        state_d      = ST_ERR;
                    end else begin
                        sp_d           = sp_q - SP_W'(1);
                        close_valid_d  = 1'b1;
                        doc_complete_d = (sp_q == SP_W'(1));
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything but keeps tracking elem_done.
    always_ff @(posedge clock) begin
        elem_done_q <= bus.elem_done;
        if (reset) begin
            state_q        <= ST_IDLE;
            cap_tag_q      <= TAG_W'(0);
            cap_close_q    <= 1'b0;
            sp_q           <= SP_W'(0);
            node_valid_q   <= 1'b0;
            node_tag_q     <= TAG_W'(0);
            node_parent_q  <= TAG_W'(0);
            node_depth_q   <= SP_W'(0);
            close_valid_q  <= 1'b0;
            doc_complete_q <= 1'b0;
            error_q        <= 1'b0;
            error_code_q   <= 2'b00;
        end else begin
            state_q        <= state_d;
            cap_tag_q      <= cap_tag_d;
            cap_close_q    <= cap_close_d;
            sp_q           <= sp_d;
            node_valid_q   <= node_valid_d;
            node_tag_q     <= node_tag_d;
            node_parent_q  <= node_parent_d;
            node_depth_q   <= node_depth_d;
            close_valid_q  <= close_valid_d;
            doc_complete_q <= doc_complete_d;
            error_q        <= error_d;
            error_code_q   <= error_code_d;
        end
    end

    // Stack storage: contents are don't-care after reset, so only pushes write it.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            stack_q[sp_q[PTR_W-1:0]] <= cap_tag_q;
        end
    end

    assign bus.node_valid   = node_valid_q;
    assign bus.node_tag     = node_tag_q;
    assign bus.node_parent  = node_parent_q;
    assign bus.node_depth   = node_depth_q;
    assign bus.close_valid  = close_valid_q;
    assign bus.doc_complete = doc_complete_q;
    assign bus.depth        = sp_q;
    assign bus.error        = error_q;
    assign bus.error_code   = error_code_q;
endmodule

// File: tb/tb_element_stack.sv
// Self-checking bench for element_stack: directed scenarios plus random open/close
// traffic compared against a queue-based model of the element tree.
module tb_element_stack;
    localparam int TAG_W    = 3;
    localparam int DEPTH    = 4;
    localparam int VOID_TAG = 5;
    localparam int TAG_DIV  = 1;
    localparam int TAG_P    = 2;
    localparam int TAG_BODY = 3;
    localparam int TAG_A    = 4;
    localparam int TAG_IMG  = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // model state
    int mstack[$];
    bit m_err;
    int m_code;
    int m_ntag, m_npar, m_ndep;

    always #5 clock = ~clock;

    element_stack_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

    element_stack #(.TAG_W(TAG_W), .DEPTH(DEPTH), .VOID_TAG(VOID_TAG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstack.delete();
        m_err  = 1'b0;
        m_code = 0;
        m_ntag = 0;
        m_npar = 0;
        m_ndep = 0;
    endtask

    // Apply one parsed tag to the model tree; returns the expected pulses.
    task automatic model_apply(input bit cl, input int tag, output bit nv, output bit cv, output bit dc);
        nv = 1'b0; cv = 1'b0; dc = 1'b0;
        if (!m_err) begin
            if (!cl) begin
                if (tag == VOID_TAG || mstack.size() < DEPTH) begin
                    nv     = 1'b1;
                    m_ntag = tag;
                    m_npar = (mstack.size() > 0) ? mstack[$] : 0;
                    m_ndep = mstack.size();
                    if (tag != VOID_TAG) mstack.push_back(tag);
                end else begin
                    m_err = 1'b1; m_code = 1;
                end
            end else begin
                if (mstack.size() == 0) begin
                    m_err = 1'b1; m_code = 2;
                end else if (tag == VOID_TAG || tag != mstack[$]) begin
                    m_err = 1'b1; m_code = 3;
                end else begin
                    void'(mstack.pop_back());
                    cv = 1'b1;
                    dc = (mstack.size() == 0);
                end
            end
        end
    endtask

    task automatic check_state(input string name, input bit nv, input bit cv, input bit dc);
        chk({name, ".node_valid"},   bus.node_valid,   nv);
        chk({name, ".close_valid"},  bus.close_valid,  cv);
        chk({name, ".doc_complete"}, bus.doc_complete, dc);
        chk({name, ".depth"},        bus.depth,        mstack.size());
        chk({name, ".error"},        bus.error,        m_err);
        chk({name, ".error_code"},   bus.error_code,   m_code);
        chk({name, ".node_tag"},     bus.node_tag,     m_ntag);
        chk({name, ".node_parent"},  bus.node_parent,  m_npar);
        chk({name, ".node_depth"},   bus.node_depth,   m_ndep);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset            = 1'b1;
        bus.elem_done    = 1'b0;
        bus.elem_tag     = '0;
        bus.elem_closing = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_state("reset", 1'b0, 1'b0, 1'b0);
    endtask

    // One parser event: raise elem_done, check nothing yet after one edge, check all after two.
    task automatic send(input string name, input bit cl, input int tag);
        bit nv, cv, dc;
        int tv;
        tv = tag;
        model_apply(cl, tag, nv, cv, dc);
        @(negedge clock);
        bus.elem_done    = 1'b1;
        bus.elem_tag     = tv[TAG_W-1:0];
        bus.elem_closing = cl;
        @(posedge clock); #1;
        chk({name, ".early_node"},  bus.node_valid,  1'b0);
        chk({name, ".early_close"}, bus.close_valid, 1'b0);
        @(posedge clock); #1;
        check_state(name, nv, cv, dc);
        @(negedge clock);
        bus.elem_done = 1'b0;
    endtask

    initial begin
        int cnt;
        bit nv, cv, dc;
        bit cl;
        int tag;
        bus.elem_done    = 1'b0;
        bus.elem_tag     = '0;
        bus.elem_closing = 1'b0;

        // div/p nesting
        do_reset();
        send("open_div",  1'b0, TAG_DIV);
        send("open_p",    1'b0, TAG_P);
        send("close_p",   1'b1, TAG_P);
        send("close_div", 1'b1, TAG_DIV);

        // void element under body
        do_reset();
        send("open_body",  1'b0, TAG_BODY);
        send("open_img",   1'b0, TAG_IMG);
        send("close_body", 1'b1, TAG_BODY);

        // mismatch, then ERR absorbs
        do_reset();
        send("open_div2", 1'b0, TAG_DIV);
        send("close_p2",  1'b1, TAG_P);
        send("open_a",    1'b0, TAG_A);

        // underflow
        do_reset();
        send("close_empty", 1'b1, TAG_DIV);

        // closing a void tag is a mismatch
        do_reset();
        send("open_div3",  1'b0, TAG_DIV);
        send("close_img",  1'b1, TAG_IMG);

        // overflow then reset
        do_reset();
        for (int i = 0; i < DEPTH; i++) send("fill", 1'b0, i);
        send("overflow", 1'b0, TAG_A);
        do_reset();

        // level held across reset release is not an event
        @(negedge clock);
        reset            = 1'b1;
        bus.elem_done    = 1'b1;
        bus.elem_tag     = TAG_W'(TAG_DIV);
        bus.elem_closing = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        repeat (5) begin @(posedge clock); #1; cnt += int'(bus.node_valid); end
        chk("held_no_event", cnt, 0);
        chk("held_depth", bus.depth, 0);
        @(negedge clock);
        bus.elem_done = 1'b0;
        @(negedge clock);
        bus.elem_done = 1'b1;
        model_apply(1'b0, TAG_DIV, nv, cv, dc);
        cnt = 0;
        repeat (12) begin @(posedge clock); #1; cnt += int'(bus.node_valid); end
        chk("held_single_event", cnt, 1);
        check_state("held_after", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        bus.elem_done = 1'b0;

        // random traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 20; k++) begin
                if (mstack.size() > 0) cl = ($urandom_range(0, 1) == 1);
                else                   cl = ($urandom_range(0, 9) == 0);
                if (cl && mstack.size() > 0 && $urandom_range(0, 3) != 0) tag = mstack[$];
                else tag = $urandom_range(0, 7);
                send("rand", cl, tag);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
